// File: rtl/ctrl_code_sequencer_if.sv
// Command/status bundle between the board command logic and the code sequencer.
// The master drives start/abort/mode/hold; the slave returns the control code and status.
interface ctrl_code_sequencer_if #(
   parameter int HOLD_W = 8
);
   logic              start;
   logic              abort;
   logic [1:0]        mode;
   logic [HOLD_W-1:0] hold;
   logic [3:0]        code;
   logic              busy;
   logic              done;

   modport master (
      output start, abort, mode, hold,
      input  code, busy, done
   );

   modport slave (
      input  start, abort, mode, hold,
      output code, busy, done
   );
endinterface

// File: rtl/ctrl_code_sequencer.sv
// Timed reset/enable/operate sequence driving the ALU control-table code {d,c,b,a}.
// All outputs are registered from the next-state decode, so only legal codes ever appear.
module ctrl_code_sequencer #(
   parameter int RST_CYCLES = 4,
   parameter int HOLD_W     = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   ctrl_code_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RST  = 3'd1,
      S_EN   = 3'd2,
      S_OP   = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   localparam int         CNT_W     = (HOLD_W > 8) ? HOLD_W : 8;
   localparam logic [3:0] C_NEUTRAL = 4'b0100;
   localparam logic [3:0] C_RESET   = 4'b1111;
   localparam logic [3:0] C_ENABLE  = 4'b1010;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [1:0]        r_mode;
   logic [HOLD_W-1:0] r_hold_m1;
   logic [3:0]        r_code;
   logic              r_busy;
   logic              r_done;
   logic [3:0]        w_code_nxt;
   logic              w_busy_nxt;
   logic              w_done_nxt;
   logic              w_start_ok;
   logic              w_rst_last;
   logic              w_op_last;

   function automatic logic [3:0] map_mode(input logic [1:0] mode);
      logic [3:0] code;
      case (mode)
         2'b00:   code = 4'b0000;
         2'b01:   code = 4'b0001;
         2'b10:   code = 4'b0011;
         default: code = 4'b0010;
      endcase
      return code;
   endfunction

   // Store H-1 so the OP comparison never needs a counter wider than HOLD_W.
   function automatic logic [HOLD_W-1:0] hold_minus_one(input logic [HOLD_W-1:0] hold);
      return (hold == '0) ? '0 : hold - HOLD_W'(1);
   endfunction

   assign w_start_ok = (r_state == S_IDLE) && bus.start && !bus.abort;
   assign w_rst_last = (r_cnt == CNT_W'(RST_CYCLES - 1));
   assign w_op_last  = (r_cnt == CNT_W'(r_hold_m1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_start_ok) w_state_nxt = S_RST;
         S_RST: begin
            if (bus.abort)       w_state_nxt = S_IDLE;
            else if (w_rst_last) w_state_nxt = S_EN;
         end
         S_EN:   w_state_nxt = bus.abort ? S_IDLE : S_OP;
         S_OP: begin
            if (bus.abort)      w_state_nxt = S_IDLE;
            else if (w_op_last) w_state_nxt = S_FIN;
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_code_nxt = C_NEUTRAL;
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      case (w_state_nxt)
         S_RST: begin
            w_code_nxt = C_RESET;
            w_busy_nxt = 1'b1;
         end
         S_EN: begin
            w_code_nxt = C_ENABLE;
            w_busy_nxt = 1'b1;
         end
         S_OP: begin
            w_code_nxt = map_mode(r_mode);
            w_busy_nxt = 1'b1;
         end
         S_FIN:   w_done_nxt = 1'b1;
         default: w_code_nxt = C_NEUTRAL;
      endcase
   end

   // Phase counter restarts on every state change and only advances in timed states.
   always_comb begin
      if (w_state_nxt != r_state) begin
         w_cnt_nxt = '0;
      end else if ((r_state == S_RST) || (r_state == S_OP)) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
         w_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_mode    <= '0;
         r_hold_m1 <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_start_ok) begin
            r_mode    <= bus.mode;
            r_hold_m1 <= hold_minus_one(bus.hold);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_code <= C_NEUTRAL;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_code <= w_code_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign bus.code = r_code;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule

// File: tb/tb_ctrl_code_sequencer.sv
// Bench for ctrl_code_sequencer: directed phases plus random traffic, checked against
// a timeline model that queues the expected outputs of each accepted sequence.
module tb_ctrl_code_sequencer;

   localparam int         RSTC   = 4;
   localparam int         HW     = 8;
   localparam logic [5:0] IDLE_O = {4'b0100, 1'b0, 1'b0};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   ctrl_code_sequencer_if #(.HOLD_W(HW)) u_if ();

   ctrl_code_sequencer #(
      .RST_CYCLES (RSTC),
      .HOLD_W     (HW)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Expected {code,busy,done} per upcoming cycle, and the value expected right now.
   logic [5:0] m_q[$];
   logic [5:0] m_last = IDLE_O;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] op_code(input logic [1:0] m);
      case (m)
         2'b00:   return 4'b0000;
         2'b01:   return 4'b0001;
         2'b10:   return 4'b0011;
         default: return 4'b0010;
      endcase
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_last = IDLE_O;
   endtask

   task automatic model_step(input logic s, input logic a, input logic [1:0] m,
                             input logic [HW-1:0] h);
      int hh;
      hh = (h == '0) ? 1 : int'(h);
      if (m_last[1] && a) begin
         m_q.delete();
         m_last = IDLE_O;
      end else if (m_q.size() > 0) begin
         m_last = m_q.pop_front();
      end else if (!m_last[0] && s && !a) begin
         for (int i = 0; i < RSTC; i++) m_q.push_back({4'b1111, 1'b1, 1'b0});
         m_q.push_back({4'b1010, 1'b1, 1'b0});
         for (int i = 0; i < hh; i++) m_q.push_back({op_code(m), 1'b1, 1'b0});
         m_q.push_back({4'b0100, 1'b0, 1'b1});
         m_last = m_q.pop_front();
      end else begin
         m_last = IDLE_O;
      end
   endtask

   task automatic check_outs(input string tag);
      check_val({tag, ".code"}, 32'(u_if.code), 32'(m_last[5:2]));
      check_val({tag, ".busy"}, 32'(u_if.busy), 32'(m_last[1]));
      check_val({tag, ".done"}, 32'(u_if.done), 32'(m_last[0]));
   endtask

   task automatic cycle(input logic s, input logic a, input logic [1:0] m,
                        input logic [HW-1:0] h);
      @(negedge clk);
      u_if.start = s;
      u_if.abort = a;
      u_if.mode  = m;
      u_if.hold  = h;
      model_step(s, a, m, h);
      @(posedge clk);
      #1;
      check_outs("cyc");
   endtask

   task automatic idle_cycle();
      cycle(1'b0, 1'b0, 2'b00, '0);
   endtask

   // Runs until done; k counts cycles after the start cycle, opc counts OP-code cycles.
   task automatic run_until_done(input bit noise, output int k, output int opc);
      bit fin;
      logic       s;
      logic [1:0] m;
      logic [HW-1:0] h;
      k   = 0;
      opc = 0;
      fin = 1'b0;
      while (!fin && k < 400) begin
         s = noise ? 1'($urandom) : 1'b0;
         m = noise ? 2'($urandom) : 2'b00;
         h = noise ? HW'($urandom) : '0;
         cycle(s, 1'b0, m, h);
         k++;
         if (u_if.busy && u_if.code != 4'b1111 && u_if.code != 4'b1010) opc++;
         if (u_if.done) fin = 1'b1;
      end
      if (!fin) check_val("run_timeout", 32'(u_if.done), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, opc;
      logic [1:0] modes[3];
      u_if.start = 1'b1;
      u_if.abort = 1'b0;
      u_if.mode  = 2'b11;
      u_if.hold  = '0;
      rst_n = 1'b0;
      model_reset();

      repeat (3) begin
         @(posedge clk);
         #1;
         check_outs("reset");
      end
      @(negedge clk);
      u_if.start = 1'b0;
      rst_n = 1'b1;
      repeat (5) idle_cycle();

      // Nominal: mode 01, hold 3.
      cycle(1'b1, 1'b0, 2'b01, HW'(3));
      run_until_done(1'b0, k, opc);
      check_val("nom_latency", 32'(k + 1), 32'(RSTC + 2 + 3));
      check_val("nom_op_len", 32'(opc), 32'd3);

      // hold=0 behaves as a single OP cycle for every mode.
      modes[0] = 2'b11; modes[1] = 2'b00; modes[2] = 2'b10;
      foreach (modes[i]) begin
         idle_cycle();
         cycle(1'b1, 1'b0, modes[i], '0);
         run_until_done(1'b0, k, opc);
         check_val("h0_latency", 32'(k + 1), 32'(RSTC + 3));
         check_val("h0_op_len", 32'(opc), 32'd1);
      end

      // Abort in the second OP cycle, then restart two cycles later.
      idle_cycle();
      cycle(1'b1, 1'b0, 2'b01, HW'(5));
      repeat (RSTC + 2) idle_cycle();
      cycle(1'b0, 1'b1, 2'b01, HW'(5));
      check_val("abort_busy", 32'(u_if.busy), 32'd0);
      check_val("abort_code", 32'(u_if.code), 32'h4);
      idle_cycle();
      cycle(1'b1, 1'b0, 2'b01, HW'(5));
      run_until_done(1'b0, k, opc);
      check_val("post_abort_latency", 32'(k + 1), 32'(RSTC + 2 + 5));

      // Input noise mid-sequence must not change the latched sequence.
      idle_cycle();
      cycle(1'b1, 1'b0, 2'b10, HW'(4));
      run_until_done(1'b1, k, opc);
      check_val("noise_latency", 32'(k + 1), 32'(RSTC + 2 + 4));
      check_val("noise_op_len", 32'(opc), 32'd4);
      cycle(1'b1, 1'b0, 2'b01, HW'(2));
      check_val("fin_start_ignored", 32'(u_if.busy), 32'd0);
      idle_cycle();

      cycle(1'b1, 1'b1, 2'b11, HW'(3));
      check_val("start_abort_idle", 32'(u_if.busy), 32'd0);
      idle_cycle();

      // Maximum hold completes exactly.
      cycle(1'b1, 1'b0, 2'b00, HW'(255));
      run_until_done(1'b0, k, opc);
      check_val("hmax_latency", 32'(k + 1), 32'(RSTC + 2 + 255));
      check_val("hmax_op_len", 32'(opc), 32'd255);
      idle_cycle();

      // Asynchronous reset between edges while in OP.
      cycle(1'b1, 1'b0, 2'b11, HW'(20));
      repeat (RSTC + 3) idle_cycle();
      check_val("pre_areset_busy", 32'(u_if.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outs("areset");
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycle();
      cycle(1'b1, 1'b0, 2'b01, HW'(2));
      run_until_done(1'b0, k, opc);
      check_val("post_areset_latency", 32'(k + 1), 32'(RSTC + 2 + 2));

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         logic s, a;
         logic [1:0] m;
         logic [HW-1:0] h;
         s = ($urandom_range(0, 5) == 0);
         a = ($urandom_range(0, 39) == 0);
         m = 2'($urandom);
         h = ($urandom_range(0, 9) == 0) ? HW'($urandom) : HW'($urandom_range(0, 7));
         cycle(s, a, m, h);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ctrl_code_sequencer.md
# ctrl_code_sequencer

Generates the 4-bit control code {d,c,b,a} consumed by the ALU control-table decoder. It replaces manual switch entry with a timed, handshaked sequence:
- reset code
- enable code
- operation code held for a programmable count
- return to a neutral code

It sits between the board-level command logic (start/mode/hold) and the decoder's four code inputs.

## Interface
- RST_CYCLES, default 4: cycles the reset code (1111) is held; legal range 1–255.
- HOLD_W, default 8: width of the hold-count input.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  request a sequence; sampled only in IDLE.
- abort  in  1  terminate any running sequence.
- mode  in  2  operation select, latched on accepted start.
- hold  in  HOLD_W  OP-phase length in cycles, latched on accepted start; 0 is treated as 1.
- code  out  4  control code {d,c,b,a} to the decoder; registered.
- busy  out  1  high while a sequence is running; registered.
- done  out  1  one-cycle pulse on normal completion; registered.

## Operation
- Neutral code is 0100, which decodes to rst=0, enable=0, arithmetic=0.
- Mode map to OP code:
  - 00 → 0000 (arithmetic)
  - 01 → 0001 (arithmetic)
  - 10 → 0011 (arithmetic)
  - 11 → 0010 (logic)
- States and outputs:
  - IDLE: code=0100, busy=0.
  - RST: code=1111, busy=1; lasts RST_CYCLES cycles.
  - EN: code=1010, busy=1; lasts 1 cycle.
  - OP: code=mapped mode, busy=1; lasts H=max(hold,1) cycles.
  - FIN: code=0100, busy=0, done=1; lasts 1 cycle, then IDLE.
- Transitions:
  - IDLE→RST on start=1 and abort=0.
  - RST→EN when the phase counter reaches RST_CYCLES.
  - EN→OP unconditionally.
  - OP→FIN when the phase counter reaches H.
  - FIN→IDLE unconditionally.
- A start accepted in FIN is ignored. start while busy is ignored; no queuing.
- abort=1 in RST, EN or OP: next state is IDLE with code=0100, busy=0, and no done pulse. abort in FIN or IDLE has no effect; the done pulse in FIN is still issued.
- start and abort together in IDLE: abort wins, and the block stays in IDLE.
- Latched mode and hold do not change while busy. Input changes mid-sequence have no effect.
- Phase counter: 8 bits in RST, HOLD_W bits in OP. It is cleared on every state entry and never wraps. The hold=2^HOLD_W−1 case must complete exactly and not overflow early.
- code only ever takes the values 0100, 1111, 1010 or a mapped OP code. No intermediate or glitch code is ever registered.

## Timing
- Reset values while rst_n=0: code=0100, busy=0, done=0, state=IDLE, counters=0, latches=0. These apply immediately (asynchronously) and hold until the first clk edge after rst_n rises.
- rst_n asserted mid-sequence: outputs drop to reset values at once. Only a fresh start after reset release restarts the sequence.
- For start sampled high at edge T:
  - code=1111 and busy=1 for cycles T+1 .. T+RST_CYCLES.
  - code=1010 at T+RST_CYCLES+1.
  - OP code for cycles T+RST_CYCLES+2 .. T+RST_CYCLES+1+H.
  - FIN at T+RST_CYCLES+2+H: done=1, busy=0, code=0100.
- Total latency from start to done is RST_CYCLES+2+H cycles.
- Earliest next accepted start is the edge at the end of the first IDLE cycle after FIN.
- abort sampled at edge A (state RST/EN/OP): IDLE outputs are visible from cycle A+1.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → code=0100, busy=0, done=0, even with start=1 held during reset.
- Nominal, RST_CYCLES=4: start at edge 10, mode=01, hold=3 → code 1111 on cycles 11–14, 1010 on 15, 0001 on 16–18; done=1 and code=0100 on 19; busy high on 11–18 only.
- hold=0 with mode=11 → OP code 0010 for exactly 1 cycle; done 7 cycles after start. Repeat with mode=00 and 10 → OP codes 0000 and 0011.
- Abort: assert abort in the 2nd OP cycle → code=0100 and busy=0 on the next cycle, no done. A start two cycles later runs a full clean sequence.
- Ignored inputs:
  - start pulses during RST/OP → no effect on length.
  - mode/hold changed mid-sequence → no effect.
  - start+abort together in IDLE → stays IDLE.
- Async reset mid-OP: drop rst_n between edges → code=0100 and busy=0 before the next edge. hold=255 (HOLD_W=8) → OP lasts exactly 255 cycles.
